// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload scheduler.
//   prd_req_t   : request broadcast to every predecoder (the raw instruction word)
//   prd_rsp_t   : per-accelerator predecoder verdict (accept, produces writeback)
//   acc_rsp_t   : one accelerator result (data + destination register)
//   req_state_e : request-side FSM state
package acc_pkg;

    typedef struct packed {
        logic [31:0] q_instr_data;
    } prd_req_t;

    typedef struct packed {
        logic p_accept;
        logic p_writeback;
    } prd_rsp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } acc_rsp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } req_state_e;

endpackage

// File: rtl/acc_rr_arb.sv
// Round-robin arbiter with lock-on-stall.
// The search starts at the index after the last completed grant. Once a grant
// is shown with ready_i low, that grant is frozen until ready_i comes back, so
// the downstream payload cannot change under a stalled consumer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   ready_i       : consumer ready; a grant completes when valid_o && ready_i
//   gnt_o         : one-hot grant (zero when nothing is valid)
//   valid_o       : a grant is being presented
//   idx_o         : index of the granted requester
module acc_rr_arb #(
    parameter  int N    = 4,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            ready_i,
    output logic [N-1:0]    gnt_o,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_q;
    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [IdxW-1:0] pick;
    logic            any;
    int              sum;

    // Rotate so that bit 0 of req_rot corresponds to the search start index.
    assign req_dbl = {req_i, req_i} >> ptr_q;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        pick = '0;
        any  = 1'b0;
        sum  = 0;
        for (int i = 0; i < N; i++) begin
            if (!any && req_rot[i]) begin
                any = 1'b1;
                sum = int'(ptr_q) + i;
                if (sum >= N) sum = sum - N;
                pick = IdxW'(sum);
            end
        end
    end

    assign idx_o   = lock_q ? lock_idx_q : pick;
    assign valid_o = lock_q | any;
    assign gnt_o   = valid_o ? (N'(1) << idx_o) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (valid_o) begin
            if (ready_i) begin
                lock_q <= 1'b0;
                ptr_q  <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
            end else begin
                lock_q     <= 1'b1;
                lock_idx_q <= idx_o;
            end
        end
    end

endmodule

// File: rtl/acc_offl_sched.sv
// Offload scheduler between one core and NumAcc accelerators.
// Request side: the core's instruction is broadcast to all predecoders; the
// lowest-index accepting accelerator wins. Rejects complete in the same cycle,
// accepted instructions are latched and issued one cycle later. Writeback
// instructions are tracked per accelerator and stall once MaxOutstanding are
// pending. Result side: round-robin arbitration, combinational to the core.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no pending issue; core request decoded this cycle
//   ISSUE | latched instruction presented to accelerator k_q
//
// Ports:
//   clk_i, rst_ni                         : clock, async active-low reset
//   q_valid_i/q_ready_o/q_instr_i/q_accept_o : core offload request
//   prd_req_o/prd_rsp_i                   : predecoder broadcast / responses
//   acc_q_valid_o/acc_q_ready_i/acc_q_instr_o : issue to accelerators
//   acc_p_valid_i/acc_p_ready_o/acc_p_data_i/acc_p_rd_i : accelerator results
//   p_valid_o/p_ready_i/p_data_o/p_rd_o/p_idx_o : result to core
module acc_offl_sched
    import acc_pkg::*;
#(
    parameter  int NumAcc         = 4,
    parameter  int MaxOutstanding = 4,
    localparam int IdxW           = (NumAcc > 1) ? $clog2(NumAcc) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        q_valid_i,
    output logic                        q_ready_o,
    input  logic [31:0]                 q_instr_i,
    output logic                        q_accept_o,
    output prd_req_t                    prd_req_o,
    input  prd_rsp_t [NumAcc-1:0]       prd_rsp_i,
    output logic [NumAcc-1:0]           acc_q_valid_o,
    input  logic [NumAcc-1:0]           acc_q_ready_i,
    output logic [31:0]                 acc_q_instr_o,
    input  logic [NumAcc-1:0]           acc_p_valid_i,
    output logic [NumAcc-1:0]           acc_p_ready_o,
    input  logic [NumAcc-1:0][31:0]     acc_p_data_i,
    input  logic [NumAcc-1:0][4:0]      acc_p_rd_i,
    output logic                        p_valid_o,
    input  logic                        p_ready_i,
    output logic [31:0]                 p_data_o,
    output logic [4:0]                  p_rd_o,
    output logic [IdxW-1:0]             p_idx_o
);

    req_state_e               state_q;
    logic [31:0]              instr_q;
    logic                     wb_q;
    logic [NumAcc-1:0]        acc_q_valid_q;
    logic [NumAcc-1:0][3:0]   cnt_q;

    logic                     sel_found;
    logic [IdxW-1:0]          sel_idx;
    logic                     sel_wb;
    logic                     stall;
    logic                     issue_hs;
    logic [NumAcc-1:0]        inc_vec;
    logic [NumAcc-1:0]        dec_vec;
    logic [NumAcc-1:0]        cnt_zero;

    logic [NumAcc-1:0]        arb_gnt;
    logic                     arb_valid;
    logic [IdxW-1:0]          arb_idx;
    acc_rsp_t                 sel_rsp;

    assign prd_req_o.q_instr_data = q_instr_i;

    // Descending scan so the lowest accepting index is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_wb    = 1'b0;
        for (int i = NumAcc - 1; i >= 0; i--) begin
            if (prd_rsp_i[i].p_accept) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
                sel_wb    = prd_rsp_i[i].p_writeback;
            end
        end
    end

    assign stall      = sel_found && sel_wb &&
                        (cnt_q[sel_idx] == 4'(MaxOutstanding));
    // rst_ni gating keeps the handshake outputs quiet while reset is held.
    assign q_ready_o  = rst_ni && (state_q == IDLE) && q_valid_i && !stall;
    assign q_accept_o = q_ready_o && sel_found;

    assign issue_hs   = (state_q == ISSUE) && |(acc_q_valid_q & acc_q_ready_i);

    assign acc_q_valid_o = acc_q_valid_q;
    assign acc_q_instr_o = instr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            wb_q          <= 1'b0;
            acc_q_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (q_accept_o) begin
                        instr_q       <= q_instr_i;
                        wb_q          <= sel_wb;
                        acc_q_valid_q <= NumAcc'(1) << sel_idx;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_hs) begin
                        acc_q_valid_q <= '0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // acc_q_valid_q is already one-hot on the target accelerator.
    assign inc_vec = (issue_hs && wb_q) ? acc_q_valid_q : '0;
    assign dec_vec = acc_p_valid_i & acc_p_ready_o;

    always_comb begin
        cnt_zero = '0;
        for (int k = 0; k < NumAcc; k++) cnt_zero[k] = (cnt_q[k] == 4'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NumAcc; k++) begin
                if (inc_vec[k] && !dec_vec[k]) begin
                    if (cnt_q[k] != 4'hF) cnt_q[k] <= cnt_q[k] + 4'd1;
                end else if (dec_vec[k] && !inc_vec[k]) begin
                    if (cnt_q[k] != 4'd0) cnt_q[k] <= cnt_q[k] - 4'd1;
                end
            end
        end
    end

    // A result with no writeback outstanding is still forwarded, but flagged.
    a_no_unexpected_result: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (dec_vec & ~inc_vec & cnt_zero) == '0
    );

    acc_rr_arb #(
        .N (NumAcc)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (acc_p_valid_i),
        .ready_i (p_ready_i),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    assign sel_rsp.data  = acc_p_data_i[arb_idx];
    assign sel_rsp.rd    = acc_p_rd_i[arb_idx];

    assign p_valid_o     = rst_ni && arb_valid;
    assign p_data_o      = sel_rsp.data;
    assign p_rd_o        = sel_rsp.rd;
    assign p_idx_o       = arb_idx;
    assign acc_p_ready_o = arb_gnt & {NumAcc{p_ready_i && rst_ni}};

endmodule

// File: tb/tb_acc_offl_sched.sv
module tb_acc_offl_sched;
    import acc_pkg::*;

    localparam int NA   = 4;
    localparam int MAXO = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 q_valid_i;
    logic                 q_ready_o;
    logic [31:0]          q_instr_i;
    logic                 q_accept_o;
    prd_req_t             prd_req_o;
    prd_rsp_t [NA-1:0]    prd_rsp_i;
    logic [NA-1:0]        acc_q_valid_o;
    logic [NA-1:0]        acc_q_ready_i;
    logic [31:0]          acc_q_instr_o;
    logic [NA-1:0]        acc_p_valid_i;
    logic [NA-1:0]        acc_p_ready_o;
    logic [NA-1:0][31:0]  acc_p_data_i;
    logic [NA-1:0][4:0]   acc_p_rd_i;
    logic                 p_valid_o;
    logic                 p_ready_i;
    logic [31:0]          p_data_o;
    logic [4:0]           p_rd_o;
    logic [1:0]           p_idx_o;

    logic [NA-1:0]        acc_mask;
    logic [NA-1:0]        wb_mask;

    int total = 0;
    int bad   = 0;

    acc_offl_sched #(
        .NumAcc         (NA),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .q_valid_i     (q_valid_i),
        .q_ready_o     (q_ready_o),
        .q_instr_i     (q_instr_i),
        .q_accept_o    (q_accept_o),
        .prd_req_o     (prd_req_o),
        .prd_rsp_i     (prd_rsp_i),
        .acc_q_valid_o (acc_q_valid_o),
        .acc_q_ready_i (acc_q_ready_i),
        .acc_q_instr_o (acc_q_instr_o),
        .acc_p_valid_i (acc_p_valid_i),
        .acc_p_ready_o (acc_p_ready_o),
        .acc_p_data_i  (acc_p_data_i),
        .acc_p_rd_i    (acc_p_rd_i),
        .p_valid_o     (p_valid_o),
        .p_ready_i     (p_ready_i),
        .p_data_o      (p_data_o),
        .p_rd_o        (p_rd_o),
        .p_idx_o       (p_idx_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int i = 0; i < NA; i++) begin
            prd_rsp_i[i].p_accept    = acc_mask[i];
            prd_rsp_i[i].p_writeback = wb_mask[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending issue (at most one), outstanding-writeback count per accelerator,
    // where the next round-robin search begins, and a frozen stalled grant.
    bit          m_busy;
    int          m_k;
    logic [31:0] m_instr;
    bit          m_wb;
    int          m_cnt [NA];
    int          m_start;
    bit          m_lock;
    int          m_lock_idx;

    always @(negedge clk_i) begin
        int  sel, g;
        bit  e_ready, e_accept;
        if (!rst_ni) begin
            chk("rst_outputs", {q_ready_o, q_accept_o, acc_q_valid_o, acc_p_ready_o, p_valid_o}, 32'd0);
            chk("rst_acc_q_instr", acc_q_instr_o, 32'd0);
            m_busy = 0; m_k = 0; m_instr = '0; m_wb = 0;
            for (int i = 0; i < NA; i++) m_cnt[i] = 0;
            m_start = 0; m_lock = 0; m_lock_idx = 0;
        end else begin
            sel = -1;
            for (int i = 0; i < NA; i++) if (sel < 0 && acc_mask[i]) sel = i;
            e_ready  = !m_busy && q_valid_i &&
                       !(sel >= 0 && wb_mask[sel] && m_cnt[sel] == MAXO);
            e_accept = e_ready && (sel >= 0);
            chk("q_ready", q_ready_o, e_ready);
            chk("q_accept", q_accept_o, e_accept);
            chk("prd_req", prd_req_o.q_instr_data, q_instr_i);
            chk("acc_q_valid", acc_q_valid_o, m_busy ? (32'd1 << m_k) : 32'd0);
            chk("acc_q_instr", acc_q_instr_o, m_instr);

            g = -1;
            if (m_lock) g = m_lock_idx;
            else for (int n = 0; n < NA; n++)
                if (g < 0 && acc_p_valid_i[(m_start + n) % NA]) g = (m_start + n) % NA;
            chk("p_valid", p_valid_o, g >= 0);
            if (g >= 0) begin
                chk("p_idx", p_idx_o, g);
                chk("p_data", p_data_o, acc_p_data_i[g]);
                chk("p_rd", p_rd_o, acc_p_rd_i[g]);
                chk("acc_p_ready", acc_p_ready_o, p_ready_i ? (32'd1 << g) : 32'd0);
            end else begin
                chk("acc_p_ready_idle", acc_p_ready_o, 32'd0);
            end

            // Next state: issue completion first, so a same-cycle result at
            // count zero nets out to no change.
            if (m_busy && acc_q_ready_i[m_k]) begin
                m_busy = 0;
                if (m_wb) m_cnt[m_k]++;
            end else if (e_accept) begin
                m_busy = 1; m_k = sel; m_instr = q_instr_i; m_wb = wb_mask[sel];
            end
            if (g >= 0) begin
                if (p_ready_i) begin
                    if (m_cnt[g] > 0) m_cnt[g]--;
                    m_start = (g + 1) % NA;
                    m_lock  = 0;
                end else begin
                    m_lock = 1; m_lock_idx = g;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [NA-1:0] am, input bit wm, input logic [31:0] ins);
        bit ok;
        acc_mask = am; wb_mask = wm ? am : '0; q_instr_i = ins; q_valid_i = 1'b1;
        acc_q_ready_i = '1;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            #3;
            if (q_ready_o) ok = 1;
            step();
        end
        chk("send_accepted", ok, 1);
        q_valid_i = 1'b0; acc_mask = '0; wb_mask = '0;
        step();
        acc_q_ready_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        rst_ni = 1'b0; q_valid_i = 0; q_instr_i = '0; acc_mask = '0; wb_mask = '0;
        acc_q_ready_i = '0; acc_p_valid_i = '0; acc_p_data_i = '0; acc_p_rd_i = '0;
        p_ready_i = 0;
        step(); step();
        // Outputs must stay quiet in reset despite live inputs.
        q_valid_i = 1; acc_mask = 4'b0001; acc_p_valid_i = 4'b1111; p_ready_i = 1;
        #3;
        chk("lit_rst_q_ready", q_ready_o, 0);
        chk("lit_rst_p_valid", p_valid_o, 0);
        step();
        q_valid_i = 0; acc_mask = '0; acc_p_valid_i = '0; p_ready_i = 0;
        step();
        rst_ni = 1'b1;
        step();

        // Reject: nobody accepts.
        q_valid_i = 1; q_instr_i = 32'h0000_0013; acc_mask = '0;
        #3;
        chk("lit_rej_ready", q_ready_o, 1);
        chk("lit_rej_accept", q_accept_o, 0);
        chk("lit_rej_issue", acc_q_valid_o, 0);
        step();
        q_valid_i = 0;
        #3 chk("lit_rej_issue_next", acc_q_valid_o, 0);

        // Acc 1 and 2 accept; lowest wins; ready held low 3 cycles.
        step();
        q_valid_i = 1; q_instr_i = 32'hABCD_0001; acc_mask = 4'b0110; acc_q_ready_i = '0;
        #3;
        chk("lit_acc_ready", q_ready_o, 1);
        chk("lit_acc_accept", q_accept_o, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) q_instr_i = 32'h0000_1234;
            if (c == 3) acc_q_ready_i = 4'b0010;
            #3;
            chk("lit_issue_valid", acc_q_valid_o, 4'b0010);
            chk("lit_issue_qready", q_ready_o, 0);
            chk("lit_issue_instr", acc_q_instr_o, 32'hABCD_0001);
        end
        step();
        q_valid_i = 0; acc_q_ready_i = '0; acc_mask = '0;
        #3 chk("lit_issue_done", acc_q_valid_o, 0);
        step();

        // Outstanding writebacks so every result below is expected.
        send(4'b0001, 1, 32'h10); send(4'b0001, 1, 32'h11); send(4'b0001, 1, 32'h12);
        send(4'b0010, 1, 32'h20);
        send(4'b0100, 1, 32'h30); send(4'b0100, 1, 32'h31);
        send(4'b1000, 1, 32'h40);

        // Round robin with all valid, consumer always ready.
        acc_p_valid_i = 4'b1111; p_ready_i = 1;
        for (int i = 0; i < NA; i++) begin
            acc_p_data_i[i] = 32'h100 + i;
            acc_p_rd_i[i]   = 5'(i + 1);
        end
        for (int j = 0; j < 5; j++) begin
            #3;
            chk("lit_rr_idx", p_idx_o, seq[j]);
            chk("lit_rr_valid", p_valid_o, 1);
            step();
        end
        acc_p_valid_i = '0;

        // Stalled grant on acc 2 while acc 0 arrives.
        acc_p_valid_i = 4'b0100; p_ready_i = 0;
        acc_p_data_i[2] = 32'hCAFE_0002; acc_p_rd_i[2] = 5'd9; acc_p_data_i[0] = 32'hBEEF_0000;
        #3;
        chk("lit_lock_idx0", p_idx_o, 2);
        chk("lit_lock_data0", p_data_o, 32'hCAFE_0002);
        step();
        acc_p_valid_i = 4'b0101;
        #3;
        chk("lit_lock_idx1", p_idx_o, 2);
        chk("lit_lock_data1", p_data_o, 32'hCAFE_0002);
        chk("lit_lock_pready", acc_p_ready_o, 0);
        step();
        p_ready_i = 1;
        #3;
        chk("lit_lock_idx2", p_idx_o, 2);
        chk("lit_lock_pready2", acc_p_ready_o, 4'b0100);
        step();
        acc_p_valid_i = 4'b0001;
        #3 chk("lit_lock_next", p_idx_o, 0);
        step();
        acc_p_valid_i = '0; p_ready_i = 0;

        // Outstanding limit on acc 0.
        send(4'b0001, 1, 32'h50); send(4'b0001, 1, 32'h51);
        send(4'b0001, 1, 32'h52); send(4'b0001, 1, 32'h53);
        q_valid_i = 1; acc_mask = 4'b0001; wb_mask = 4'b0001; q_instr_i = 32'h54;
        for (int c = 0; c < 3; c++) begin
            #3 chk("lit_stall", q_ready_o, 0);
            step();
        end
        acc_p_valid_i = 4'b0001; p_ready_i = 1; acc_p_data_i[0] = 32'h55;
        #3;
        chk("lit_stall_res", q_ready_o, 0);
        chk("lit_stall_pvalid", p_valid_o, 1);
        step();
        acc_p_valid_i = '0;
        #3;
        chk("lit_unstall_ready", q_ready_o, 1);
        chk("lit_unstall_accept", q_accept_o, 1);
        step();
        q_valid_i = 0; acc_mask = '0; wb_mask = '0; acc_q_ready_i = '1;
        step();
        acc_q_ready_i = '0; p_ready_i = 0;

        // Reset while an issue to acc 1 is pending with three outstanding.
        send(4'b0010, 1, 32'h60); send(4'b0010, 1, 32'h61); send(4'b0010, 1, 32'h62);
        q_valid_i = 1; acc_mask = 4'b0010; wb_mask = 4'b0010; q_instr_i = 32'h77;
        #3 chk("lit_pre_rst_ready", q_ready_o, 1);
        step();
        q_valid_i = 0; acc_mask = '0; wb_mask = '0;
        #3 chk("lit_pre_rst_issue", acc_q_valid_o, 4'b0010);
        step();
        rst_ni = 0; q_valid_i = 1; acc_mask = 4'b0010; acc_p_valid_i = 4'b0010; p_ready_i = 1;
        #3;
        chk("lit_mid_rst_issue", acc_q_valid_o, 0);
        chk("lit_mid_rst_qready", q_ready_o, 0);
        chk("lit_mid_rst_pready", acc_p_ready_o, 0);
        chk("lit_mid_rst_instr", acc_q_instr_o, 0);
        step();
        q_valid_i = 0; acc_mask = '0; acc_p_valid_i = '0; p_ready_i = 0;
        step();
        rst_ni = 1;
        #3 chk("lit_post_rst_idle", acc_q_valid_o, 0);
        step();
        // Counts were cleared: four writebacks go through, the fifth stalls.
        send(4'b0010, 1, 32'h80); send(4'b0010, 1, 32'h81);
        send(4'b0010, 1, 32'h82); send(4'b0010, 1, 32'h83);
        q_valid_i = 1; acc_mask = 4'b0010; wb_mask = 4'b0010; q_instr_i = 32'h84;
        #3 chk("lit_post_rst_stall", q_ready_o, 0);
        step();
        q_valid_i = 0; acc_mask = '0; wb_mask = '0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
